// File: rtl/ysyx_25060166_mem_arbiter.sv
// ============================================================================
// Module   : ysyx_25060166_mem_arbiter
// Brief    : Round-robin 2:1 arbiter sharing one memory port between IFU and LSU
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_25060166_mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [WIDTH-1:0]   ifu_addr,
    output logic               ifu_rsp_valid,
    input  logic               ifu_rsp_ready,
    output logic [WIDTH-1:0]   ifu_rdata,
    output logic               ifu_rsp_err,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [WIDTH-1:0]   lsu_addr,
    input  logic               lsu_wen,
    input  logic [WIDTH-1:0]   lsu_wdata,
    input  logic [WIDTH/8-1:0] lsu_wmask,
    output logic               lsu_rsp_valid,
    input  logic               lsu_rsp_ready,
    output logic [WIDTH-1:0]   lsu_rdata,
    output logic               lsu_rsp_err,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               mem_wen,
    output logic [WIDTH/8-1:0] mem_wmask,
    input  logic               mem_rsp_valid,
    output logic               mem_rsp_ready,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_rsp_err,
    output logic               busy,
    output logic               owner
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT_RSP = 2'd2;
    localparam logic [1:0] c_RESP     = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_wen;
    logic [WIDTH/8-1:0] r_wmask;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_err;
    logic               w_grant_ifu;
    logic               w_grant_lsu;
    logic               w_owner_take;

    // On a tie the requester that was not granted last time wins.
    assign w_grant_lsu  = lsu_req_valid && (!ifu_req_valid || !r_last_grant);
    assign w_grant_ifu  = ifu_req_valid && !w_grant_lsu;
    assign w_owner_take = r_owner ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:     if (w_grant_ifu || w_grant_lsu) w_next_state = c_ISSUE;
            c_ISSUE:    if (mem_req_ready)              w_next_state = c_WAIT_RSP;
            c_WAIT_RSP: if (mem_rsp_valid)              w_next_state = c_RESP;
            c_RESP:     if (w_owner_take)               w_next_state = c_IDLE;
            default:                                    w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        case (r_state)
            c_IDLE: begin
                ifu_req_ready = w_grant_ifu;
                lsu_req_ready = w_grant_lsu;
            end
            c_ISSUE:    mem_req_valid = 1'b1;
            c_WAIT_RSP: mem_rsp_ready = 1'b1;
            c_RESP: begin
                ifu_rsp_valid = !r_owner;
                lsu_rsp_valid = r_owner;
            end
            default: ;
        endcase
    end

    // Request/response holding registers; IFU requests are forced to reads.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_wmask      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == c_IDLE && (w_grant_ifu || w_grant_lsu)) begin
                r_owner      <= w_grant_lsu;
                r_last_grant <= w_grant_lsu;
                r_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
                r_wen        <= w_grant_lsu && lsu_wen;
                r_wdata      <= w_grant_lsu ? lsu_wdata : '0;
                r_wmask      <= w_grant_lsu ? lsu_wmask : '0;
            end
            if (r_state == c_WAIT_RSP && mem_rsp_valid) begin
                r_rdata <= mem_rdata;
                r_err   <= mem_rsp_err;
            end
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_wen     = r_wen;
    assign mem_wmask   = r_wmask;
    assign ifu_rdata   = r_rdata;
    assign ifu_rsp_err = r_err;
    assign lsu_rdata   = r_rdata;
    assign lsu_rsp_err = r_err;
    assign busy        = (r_state != c_IDLE);
    assign owner       = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060166_mem_arbiter.sv
// ============================================================================
// Module   : tb_ysyx_25060166_mem_arbiter
// Brief    : Directed self-checking bench for the IFU/LSU memory arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_25060166_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask, mem_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, owner;

    int compared   = 0;
    int mismatched = 0;

    ysyx_25060166_mem_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .mem_rsp_err(mem_rsp_err),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory accepts immediately and answers on the following cycle; leaves DUT in RESP.
    task automatic serve(input logic [31:0] data, input logic err);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = data;
        mem_rsp_err   = err;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        settle();
    endtask

    initial begin
        resetn = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; mem_rsp_err = 0;
        step();
        step();

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        resetn = 1'b1;
        settle();
        chk("idle_no_req_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);

        // Single fetch, zero-wait memory
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        settle();
        chk("fetch_req_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h2);
        step();
        ifu_req_valid = 1'b0;
        settle();
        chk("fetch_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("fetch_mem_addr", mem_addr, 32'h8000_0000);
        chk("fetch_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("fetch_issue_no_ready", {31'd0, ifu_req_ready}, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        settle();
        chk("fetch_mem_rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("fetch_rsp_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'h2);
        chk("fetch_rdata", ifu_rdata, 32'h0000_0413);
        ifu_rsp_ready = 1'b1;
        step();
        ifu_rsp_ready = 1'b0;
        settle();
        chk("fetch_done_busy", {31'd0, busy}, 32'd0);
        chk("fetch_done_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);

        // Store forwarding
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        settle();
        chk("store_req_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h1);
        step();
        lsu_req_valid = 1'b0;
        settle();
        chk("store_mem_addr", mem_addr, 32'h8000_0100);
        chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("store_mem_wen", {31'd0, mem_wen}, 32'd1);
        chk("store_mem_wmask", {28'd0, mem_wmask}, 32'h3);
        chk("store_owner", {31'd0, owner}, 32'd1);
        serve(32'd0, 1'b0);
        chk("store_ack_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'h1);
        lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;

        // Tie, both held valid: last grant was LSU, so IFU, then LSU, then IFU
        lsu_wen = 1'b0; lsu_wmask = 4'b0000; lsu_addr = 32'h8000_0200;
        ifu_addr = 32'h8000_0004;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        settle();
        chk("tie1_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h2);
        step();
        chk("tie1_mem_addr", mem_addr, 32'h8000_0004);
        chk("tie1_ifu_wmask_zero", {28'd0, mem_wmask}, 32'h0);
        chk("tie1_busy_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h0);
        serve(32'h0000_0011, 1'b0);
        chk("tie1_rdata", {ifu_rdata[30:0], ifu_rsp_valid}, {31'h0000_0011, 1'b1});
        ifu_rsp_ready = 1'b1;
        step();
        ifu_rsp_ready = 1'b0;
        settle();
        chk("tie2_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h1);
        step();
        chk("tie2_mem_addr", mem_addr, 32'h8000_0200);
        chk("tie2_owner", {31'd0, owner}, 32'd1);
        serve(32'h0000_0022, 1'b0);
        chk("tie2_rdata", lsu_rdata, 32'h0000_0022);
        lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;
        settle();
        chk("tie3_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h2);
        step();
        ifu_req_valid = 1'b0;

        // Backpressure on the IFU transaction while LSU keeps requesting
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("bp_req_addr", mem_addr, 32'h8000_0004);
            chk("bp_no_grant", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h0);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_ready", {30'd0, mem_rsp_ready, mem_req_valid}, 32'h2);
            chk("bp_wait_busy", {30'd0, busy, lsu_req_ready}, 32'h2);
            step();
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0033;
        step();
        mem_rsp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_held", {ifu_rdata[30:0], ifu_rsp_valid}, {31'h0000_0033, 1'b1});
            chk("bp_rsp_no_grant", {30'd0, lsu_req_ready, mem_rsp_ready}, 32'h0);
            step();
        end
        ifu_rsp_ready = 1'b1;
        step();
        ifu_rsp_ready = 1'b0;

        // Error pass-through on an LSU load to address 0
        lsu_addr = 32'h0000_0000;
        settle();
        chk("err_req_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h1);
        step();
        lsu_req_valid = 1'b0;
        chk("err_mem_addr", mem_addr, 32'h0000_0000);
        serve(32'h0000_0000, 1'b1);
        chk("err_rsp", {29'd0, lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 32'h6);
        chk("err_rdata", lsu_rdata, 32'h0000_0000);
        lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;

        // Reset while waiting for memory
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rstw_in_wait", {31'd0, mem_rsp_ready}, 32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        settle();
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_rsp_valid", {29'd0, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready}, 32'd0);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        settle();
        chk("rstw_tie_ifu", {30'd0, ifu_req_ready, lsu_req_ready}, 32'h2);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_25060166_mem_arbiter.md
# ysyx_25060166_mem_arbiter

Two-to-one memory arbiter that shares the single instruction/data memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores) in the multicycle RV32E core. It accepts one request at a time from either requester and forwards it to the memory port. It returns the memory response to the requester that issued it. Only one transaction is outstanding at any time, and ties are resolved round-robin.

## Interface
- WIDTH, 32, address/data width (matches `ysyx_25060166_WIDTH`)
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  WIDTH  fetch address
- ifu_rsp_valid  out  1  fetch data valid
- ifu_rsp_ready  in  1  IFU takes response
- ifu_rdata  out  WIDTH  fetched instruction
- ifu_rsp_err  out  1  fetch bus error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  WIDTH  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  WIDTH  store data
- lsu_wmask  in  WIDTH/8  store byte mask
- lsu_rsp_valid  out  1  load data / store ack valid
- lsu_rsp_ready  in  1  LSU takes response
- lsu_rdata  out  WIDTH  load data
- lsu_rsp_err  out  1  load/store bus error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wdata  out  WIDTH  forwarded address / write data
- mem_wen  out  1  forwarded write enable
- mem_wmask  out  WIDTH/8  forwarded byte mask
- mem_rsp_valid  in  1  memory response
- mem_rsp_ready  out  1  arbiter takes memory response
- mem_rdata  in  WIDTH  memory read data
- mem_rsp_err  in  1  memory error
- busy  out  1  state != IDLE
- owner  out  1  current/last granted requester, 0 = IFU, 1 = LSU

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE
  - Grant logic is combinational from the req_valid inputs and the last_grant register.
  - If only one requester is valid, it wins. If both are valid, the one not equal to last_grant wins.
  - The winner's req_ready is 1 and the loser's is 0. Both are 0 when neither is valid.
  - On handshake: latch addr/wen/wdata/wmask into request registers, set owner and last_grant to the winner, go to ISSUE.
  - IFU requests latch wen=0 and wmask=0.
- ISSUE
  - mem_req_valid=1, driven from the request registers and held stable.
  - On mem_req_ready=1, go to WAIT_RSP.
- WAIT_RSP
  - mem_rsp_ready=1.
  - On mem_rsp_valid=1, latch mem_rdata and mem_rsp_err into response registers and go to RESP.
- RESP
  - The owner's rsp_valid=1 with the latched rdata/err. The other requester's rsp_valid=0.
  - On the owner's rsp_ready=1, go to IDLE.
- req_ready is 0 outside IDLE. mem_rsp_ready is 0 outside WAIT_RSP. mem_req_valid is 0 outside ISSUE.
- rdata/err outputs reflect the response registers at all times; they are only meaningful while the corresponding rsp_valid=1.
- The arbiter never alters addresses or data. Alignment checking belongs to the LSU.

## Timing
- Reset (resetn=0 at a rising edge)
  - state=IDLE, owner=0, last_grant=1 (LSU), so the first tie after reset goes to IFU.
  - Request and response registers are cleared to 0.
  - All valid/ready outputs are 0, except req_ready, which follows IDLE grant logic once resetn=1.
- Reset mid-transaction drops the transaction without a response. The memory side is reset by the same resetn.
- Request accepted at cycle N: mem_req_valid=1 from N+1.
- mem_req_ready in cycle A: mem_rsp_ready=1 from A+1.
- mem_rsp_valid in cycle M: rsp_valid=1 at M+1.
- rsp handshake in cycle K: IDLE at K+1, and a new request can be accepted in K+1.
- Minimum request-to-response time is 3 cycles when memory responds with zero wait (mem_req_ready=1 at N+1, mem_rsp_valid=1 at N+2, rsp_valid at N+3).
- mem_rsp_valid outside WAIT_RSP is ignored. Memory must not respond before its request handshake.
- A requester holding valid while the other is served waits. Round-robin bounds its wait to one transaction.

## Test plan
- Single fetch: reset; ifu_req_valid=1, ifu_addr=0x8000_0000; memory zero-wait returns 0x0000_0413 -> mem_addr=0x8000_0000, mem_wen=0, ifu_rsp_valid 3 cycles after accept with ifu_rdata=0x0000_0413, lsu_rsp_valid stays 0.
- Store forwarding: lsu_req addr=0x8000_0100, wen=1, wdata=0xDEAD_BEEF, wmask=0b0011 -> mem sees identical fields; ack returned only on lsu_rsp_valid.
- Tie after reset: both valid in the same cycle -> IFU granted first, LSU granted in the IDLE cycle after IFU's response handshake. Repeat the tie -> LSU then IFU.
- Backpressure: mem_req_ready low for 4 cycles, mem_rsp_valid delayed 5 cycles, ifu_rsp_ready low for 3 cycles -> mem_req fields stable throughout, ifu_rsp_valid held with constant rdata, no new grant while busy=1.
- Error pass-through: LSU load to 0x0000_0000 with mem_rsp_err=1, mem_rdata=0 -> lsu_rsp_err=1, lsu_rdata=0.
- Reset in WAIT_RSP: assert resetn=0 for one cycle -> next cycle state IDLE, busy=0, no rsp_valid, and the next tie goes to IFU.
